// File: rtl/mnist_vote_pkg.sv
// mnist_vote_pkg: shared FSM states, score sizing helper and default class geometry
package mnist_vote_pkg;
  localparam int CLASS_NUM_DEF = 10;
  localparam int LABEL_WIDTH_DEF = 4;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  function automatic int score_width(input int group, input int frame_num);
    return $clog2(group * frame_num + 1);
  endfunction
endpackage

// File: rtl/mnist_vote_classifier_if.sv
// mnist_vote_classifier_if: per-beat class-output stream from the LUT net; every beat is consumed, so there is no ready
interface mnist_vote_classifier_if import mnist_vote_pkg::*; #(
  parameter int USER_WIDTH = 8,
  parameter int DATA_WIDTH = CLASS_NUM_DEF
);
  logic [USER_WIDTH-1:0] user;
  logic [DATA_WIDTH-1:0] data;
  logic valid;
  modport master (output user, data, valid);
  modport slave (input user, data, valid);
endinterface

// File: rtl/mnist_vote_popcount.sv
// mnist_vote_popcount: combinational popcount of one class's GROUP output bits
module mnist_vote_popcount #(
  parameter int GROUP = 1,
  parameter int WIDTH = 1
) (
  input  logic [GROUP-1:0] bits,
  output logic [WIDTH-1:0] count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < GROUP; i++) count = count + WIDTH'(bits[i]);
  end
endmodule

// File: rtl/mnist_vote_classifier.sv
// mnist_vote_classifier: frame vote accumulation, sequential argmax and accuracy counters.
// Define MNIST_VOTE_SCORE_OUT_EN to expose the winning score on m_score.
module mnist_vote_classifier import mnist_vote_pkg::*; #(
  parameter int USER_WIDTH = 8,
  parameter int LABEL_WIDTH = LABEL_WIDTH_DEF,
  parameter int CLASS_NUM = CLASS_NUM_DEF,
  parameter int GROUP = 1,
  parameter int FRAME_NUM = 16,
  parameter int COUNT_WIDTH = 32,
  localparam int SCORE_WIDTH = score_width(GROUP, FRAME_NUM)
) (
  input  logic clk,
  input  logic reset,
  input  logic cke,
  input  logic clear,
  mnist_vote_classifier_if.slave s,
  output logic [USER_WIDTH-1:0] m_user,
  output logic [LABEL_WIDTH-1:0] m_class,
  output logic m_match,
  output logic m_valid,
  output logic [COUNT_WIDTH-1:0] total_count,
  output logic [COUNT_WIDTH-1:0] correct_count,
`ifdef MNIST_VOTE_SCORE_OUT_EN
  output logic [SCORE_WIDTH-1:0] m_score,
`endif
  output logic overrun
);
  localparam int FW = $clog2(FRAME_NUM + 1);
  state_t state, state_n;
  logic [SCORE_WIDTH-1:0] pc [CLASS_NUM];
  logic [SCORE_WIDTH-1:0] acc [CLASS_NUM];
  logic [SCORE_WIDTH-1:0] snap [CLASS_NUM];
  logic [SCORE_WIDTH-1:0] best_score;
  logic [FW-1:0] beat;
  logic [LABEL_WIDTH-1:0] idx, best;
  logic [USER_WIDTH-1:0] user_q;
  logic frame_done, start, match;
  for (genvar c = 0; c < CLASS_NUM; c++) begin : g_pc
    mnist_vote_popcount #(.GROUP(GROUP), .WIDTH(SCORE_WIDTH)) u_pc (
      .bits (s.data[c*GROUP +: GROUP]),
      .count(pc[c])
    );
  end
  assign frame_done = s.valid && beat == FW'(FRAME_NUM - 1);
  assign start = frame_done && state == IDLE;
  assign match = best == user_q[LABEL_WIDTH-1:0];
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else if (cke) state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (frame_done ? SCAN : IDLE)
            : state == SCAN ? (idx == LABEL_WIDTH'(CLASS_NUM - 1) ? DONE : SCAN)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      beat <= '0;
      idx <= '0;
      best <= '0;
      best_score <= '0;
      user_q <= '0;
      m_valid <= 1'b0;
      m_class <= '0;
      m_user <= '0;
      m_match <= 1'b0;
      total_count <= '0;
      correct_count <= '0;
      overrun <= 1'b0;
      for (int c = 0; c < CLASS_NUM; c++) begin
        acc[c] <= '0;
        snap[c] <= '0;
      end
    end else if (cke) begin
      if (s.valid) beat <= frame_done ? '0 : beat + 1'b1;
      for (int c = 0; c < CLASS_NUM; c++) begin
        if (s.valid) acc[c] <= frame_done ? '0 : acc[c] + pc[c];
        if (start) snap[c] <= acc[c] + pc[c];
      end
      if (start) begin
        user_q <= s.user;
        best <= '0;
        best_score <= acc[0] + pc[0];
        idx <= LABEL_WIDTH'(1);
      end else if (state == SCAN) begin
        // strict compare keeps the lowest index on ties
        if (snap[idx] > best_score) begin
          best <= idx;
          best_score <= snap[idx];
        end
        idx <= idx + 1'b1;
      end
      if (frame_done && state != IDLE) overrun <= 1'b1;
      m_valid <= state == DONE;
      if (state == DONE) begin
        m_class <= best;
        m_user <= user_q;
        m_match <= match;
        total_count <= &total_count ? total_count : total_count + 1'b1;
        correct_count <= (match && !(&correct_count)) ? correct_count + 1'b1 : correct_count;
      end
      if (clear) begin
        total_count <= '0;
        correct_count <= '0;
        overrun <= 1'b0;
      end
    end
  end
`ifdef MNIST_VOTE_SCORE_OUT_EN
  always_ff @(posedge clk)
    if (reset) m_score <= '0;
    else if (cke && state == DONE) m_score <= best_score;
`endif
endmodule

// File: doc/mnist_vote_classifier.md
Name: mnist_vote_classifier

Overview:
- Downstream stage of the MNIST LUT-net classifier. Consumes its per-class binary outputs plus the user/label side-band.
- Accumulates class votes over FRAME_NUM consecutive beats, where one frame is one image presented FRAME_NUM times with dithered binarisation.
- Picks the winning class with a sequential argmax scan and keeps running total/correct counters for on-board accuracy measurement.

Parameters:
- USER_WIDTH, 8, side-band width. Bits [LABEL_WIDTH-1:0] carry the expected label.
- LABEL_WIDTH, 4, label/class index width.
- CLASS_NUM, 10, number of classes.
- GROUP, 1, output bits per class. Vote = popcount of the group.
- FRAME_NUM, 16, beats accumulated per decision.
- COUNT_WIDTH, 32, width of the total/correct statistics counters.
- Derived constant SCORE_WIDTH = clog2(GROUP*FRAME_NUM+1).

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- cke, input, 1, clock enable. When low, all state holds.
- clear, input, 1, synchronous clear of the statistics counters and the overrun flag.
- s_user, input, USER_WIDTH, side-band from the net.
- s_data, input, CLASS_NUM*GROUP, net outputs. Class c occupies bits [c*GROUP +: GROUP].
- s_valid, input, 1, beat valid. There is no ready; every beat is consumed.
- m_user, output, USER_WIDTH, s_user of the last beat of the frame.
- m_class, output, LABEL_WIDTH, winning class.
- m_match, output, 1, m_class == m_user[LABEL_WIDTH-1:0].
- m_valid, output, 1, one-cycle result pulse.
- total_count, output, COUNT_WIDTH, decisions made.
- correct_count, output, COUNT_WIDTH, decisions with m_match=1.
- overrun, output, 1, sticky: a frame completed while the scan was busy.

Behaviour:
- Reset: all accumulators 0, frame counter 0, FSM IDLE, m_valid 0, m_class 0, m_user 0, m_match 0, counters 0, overrun 0. Reset mid-scan aborts the scan with no m_valid.
- Accumulate, on a cke && s_valid edge:
  - acc[c] += popcount(group c).
  - Frame counter increments. On the FRAME_NUM-th beat the frame completes.
- Frame completion, when FSM is IDLE:
  - snap[c] <= acc[c] + this beat's popcount.
  - Capture user; acc <= 0; frame counter <= 0.
  - FSM goes to SCAN with best=0, best_score=snap[0], idx=1.
- Frame completion, when FSM is not IDLE:
  - Accumulators/counter still reset; snapshot is not overwritten.
  - overrun <= 1. The frame is dropped (no m_valid for it).
- FSM IDLE -> SCAN -> DONE -> IDLE:
  - SCAN: one compare per cke edge. If snap[idx] > best_score, then best=idx. Strict greater-than, so ties go to the lowest index. idx++. Leaves SCAN after idx=CLASS_NUM-1.
  - DONE: m_valid<=1 for one cke cycle; m_class/m_user/m_match registered; total_count++; correct_count += m_match.
- Latency: the last beat is sampled at edge E0, and m_valid is high during the cycle following edge E0+CLASS_NUM.
- Outputs hold their value after m_valid drops; only m_valid pulses.
- Counters saturate at all-ones; no wrap.
- clear:
  - Zeroes counters and overrun.
  - If asserted on the DONE edge, clear wins and the counters read 0 afterwards.
  - Does not affect accumulation.
- cke=0 freezes the FSM, accumulators and m_valid, so a pulse stretches while cke is low.
- FRAME_NUM >= CLASS_NUM+2 guarantees no overrun with back-to-back beats.

Optional Feature:
- Macro MNIST_VOTE_SCORE_OUT_EN.
- Defined: adds output m_score [SCORE_WIDTH-1:0] = best_score, valid with m_valid, reset 0.
- Undefined: port and register are absent. Behaviour is otherwise identical.

Decomposition:
- Package mnist_vote_pkg: FSM state enum (IDLE, SCAN, DONE), SCORE_WIDTH function (clog2), default CLASS_NUM/LABEL_WIDTH constants.
- One sub-module, mnist_vote_popcount: combinational popcount of one GROUP slice, instantiated CLASS_NUM times.

Test Plan:
- FRAME_NUM=4, GROUP=1: 4 beats with s_data=10'b0000001000, user=3 -> m_class=3, m_match=1, total=1, correct=1. m_valid appears 11 cycles after the 4th beat.
- Tie: votes class2=4, class7=4 -> m_class=2.
- Label 5, winner 8 -> m_match=0, total increments, correct does not.
- FRAME_NUM=4, back-to-back frames, CLASS_NUM=10 -> overrun=1 after the second frame. The first result is correct and the second frame produces no m_valid. clear -> overrun=0, counters 0.
- cke toggled 50% during a scan -> same result, with latency doubled in clk cycles. Reset asserted mid-SCAN -> no m_valid, all outputs 0.
- COUNT_WIDTH=2: 5 matching decisions -> total_count=3 and correct_count=3 (saturated).
